result_write_arbiter: RTL and testbench
=======================================

RESULT_WRITE_ARBITER -- requirements
Module: result_write_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_LANES_BITS, default 2, meaning log2 of filter lane count.
REQ-002 The block SHALL have parameter NUM_LANES, default 2**NUM_LANES_BITS, meaning number of filter lanes.
REQ-003 The block SHALL have parameters WIDTH_BITS and HEIGHT_BITS, each default 8, meaning column and row address widths.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low. The ports are: clock  in  1  sole clock, all logic on posedge.
REQ-005 not_reset  in  1  asynchronous active-low reset.
REQ-006 iStart  in  1  level-sampled frame start request.
REQ-007 iValid  in  NUM_LANES  per-lane result-pixel valid.
REQ-008 iCol  in  NUM_LANES*WIDTH_BITS  lane i column at [i*WIDTH_BITS +: WIDTH_BITS].
REQ-009 iRow  in  NUM_LANES*HEIGHT_BITS  lane i row at [i*HEIGHT_BITS +: HEIGHT_BITS].
REQ-010 iData  in  NUM_LANES  per-lane binary result pixel.
REQ-011 iLaneFinished  in  NUM_LANES  per-lane "all pixels produced".
REQ-012 oReady  out  NUM_LANES  per-lane grant, combinational.
REQ-013 oLaneEnable  out  NUM_LANES  per-lane processing enable.
REQ-014 oX  out  HEIGHT_BITS  written pixel row; oY  out  WIDTH_BITS  written pixel column.
REQ-015 oData  out  1  written pixel value; oWren  out  1  one-cycle write strobe.
REQ-016 oBusy  out  1  high in RAMP/RUN; oDone  out  1  high in DONE.
REQ-017 oPixelCount  out  WIDTH_BITS+HEIGHT_BITS+1  pixels written this frame.

Function
REQ-018 The block SHALL implement states IDLE, RAMP, RUN, DONE.
REQ-019 IDLE/DONE with iStart=1 SHALL go to RAMP next cycle, clear oPixelCount, clear oLaneEnable, and clear the lane-enable counter; iStart in RAMP/RUN SHALL be ignored.
REQ-020 RAMP SHALL set oLaneEnable bit k on the k-th cycle in RAMP (bit 0 on the first), one new bit per cycle, then enter RUN the cycle after bit NUM_LANES-1 sets.
REQ-021 RAMP/RUN SHALL hold already-set enable bits; DONE SHALL clear all enable bits.
REQ-022 RUN SHALL go to DONE the cycle after a cycle in which iLaneFinished is all-ones and iValid is all-zeros.
REQ-023 oReady SHALL be all-zeros in IDLE and DONE, and oReady[i] SHALL be zero whenever oLaneEnable[i]=0.
REQ-024 In RAMP/RUN at most one oReady bit SHALL be high per cycle, selected round-robin among lanes with iValid=1 and enable=1, highest priority at (last_grant+1) mod NUM_LANES.
REQ-025 last_grant SHALL update to the granted lane on every transfer (iValid&oReady), SHALL be NUM_LANES-1 after reset so lane 0 wins first, and SHALL NOT reset on iStart.
REQ-026 Lanes SHALL hold iValid and payload stable until granted; the block SHALL NOT drop or duplicate a transfer.
REQ-027 A transfer in cycle t SHALL produce oWren=1 in cycle t+1 with oX=lane row, oY=lane column, oData=lane data (latency 1).
REQ-028 Without a transfer in cycle t, oWren SHALL be 0 in t+1 and oX/oY/oData SHALL hold.
REQ-029 oPixelCount SHALL increment by 1 per transfer and saturate at 2**(WIDTH_BITS+HEIGHT_BITS).
REQ-030 A lone valid lane SHALL be granted every cycle (full throughput, no bubble).

Reset
REQ-031 not_reset=0 SHALL immediately force state IDLE, oLaneEnable=0, oWren=0, oX=0, oY=0, oData=0, oPixelCount=0, oBusy=0, oDone=0, last_grant=NUM_LANES-1, including mid-frame; oReady SHALL be 0 while in IDLE.

Verification
REQ-032 Reset, iStart pulse at cycle 0 -> oLaneEnable 0001,0011,0111,1111 on cycles 1-4, oBusy=1, RUN from cycle 5.
REQ-033 RUN, iValid=1111 held 8 cycles -> grants 0,1,2,3,0,1,2,3, oWren=1 each following cycle, oPixelCount=8.
REQ-034 RUN, only lane 2 valid with row=0x10,col=0x20,data=1 -> oReady=0100 same cycle, next cycle oWren=1,oX=0x10,oY=0x20,oData=1.
REQ-035 iLaneFinished=1111 while lane 3 still valid -> stays RUN until lane 3 granted; DONE two cycles after the last grant, oDone=1, oLaneEnable=0000, oReady=0.
REQ-036 not_reset deasserted low mid-RUN with iValid=1111 -> all outputs at reset values that cycle; lane 0 granted first after restart.

Source files
------------

// File: rtl/result_write_arbiter.sv
// Result write arbiter: ramps filter lanes on at frame start, grants one valid
// lane per cycle round-robin, and forwards the granted pixel to a one-cycle
// write port while counting the pixels written in the frame.
module result_write_arbiter #(
  parameter int unsigned NUM_LANES_BITS = 2,
  parameter int unsigned NUM_LANES      = 2 ** NUM_LANES_BITS,
  parameter int unsigned WIDTH_BITS     = 8,
  parameter int unsigned HEIGHT_BITS    = 8
) (
  input  logic                              clock,
  input  logic                              not_reset,
  input  logic                              iStart,
  input  logic [NUM_LANES-1:0]              iValid,
  input  logic [NUM_LANES*WIDTH_BITS-1:0]   iCol,
  input  logic [NUM_LANES*HEIGHT_BITS-1:0]  iRow,
  input  logic [NUM_LANES-1:0]              iData,
  input  logic [NUM_LANES-1:0]              iLaneFinished,
  output logic [NUM_LANES-1:0]              oReady,
  output logic [NUM_LANES-1:0]              oLaneEnable,
  output logic [HEIGHT_BITS-1:0]            oX,
  output logic [WIDTH_BITS-1:0]             oY,
  output logic                              oData,
  output logic                              oWren,
  output logic                              oBusy,
  output logic                              oDone,
  output logic [WIDTH_BITS+HEIGHT_BITS:0]   oPixelCount
);

  localparam int unsigned LaneW = (NUM_LANES_BITS > 0) ? NUM_LANES_BITS : 1;
  localparam int unsigned CntW  = WIDTH_BITS + HEIGHT_BITS + 1;
  // Count saturates at 2**(WIDTH_BITS+HEIGHT_BITS), i.e. only the MSB set.
  localparam logic [CntW-1:0]  CntMax   = {1'b1, {(CntW-1){1'b0}}};
  localparam logic [LaneW-1:0] LastLane = LaneW'(NUM_LANES - 1);
  localparam logic [LaneW:0]   RampEnd  = (LaneW+1)'(NUM_LANES);

  typedef enum logic [1:0] {StIdle, StRamp, StRun, StDone} state_e;

  state_e               state;
  logic [LaneW:0]       ramp_cnt;
  logic [LaneW-1:0]     last_grant;
  logic [LaneW-1:0]     grant_lane;
  logic                 grant_valid;
  logic                 active;
  logic [NUM_LANES-1:0] req;

  assign active = (state == StRamp) || (state == StRun);
  assign req    = iValid & oLaneEnable;
  assign oBusy  = active;
  assign oDone  = (state == StDone);

  // Round-robin pick: search starts one lane past the last granted lane.
  always_comb begin
    grant_valid = 1'b0;
    grant_lane  = '0;
    oReady      = '0;
    for (int unsigned off = 1; off <= NUM_LANES; off++) begin
      if (active && !grant_valid &&
          req[LaneW'((32'(last_grant) + off) % NUM_LANES)]) begin
        grant_valid = 1'b1;
        grant_lane  = LaneW'((32'(last_grant) + off) % NUM_LANES);
      end
    end
    if (grant_valid) begin
      oReady[grant_lane] = 1'b1;
    end
  end

  // Frame FSM, lane-enable ramp, write port and pixel counter.
  always_ff @(posedge clock or negedge not_reset) begin
    if (!not_reset) begin
      state       <= StIdle;
      ramp_cnt    <= '0;
      oLaneEnable <= '0;
      last_grant  <= LastLane;
      oWren       <= 1'b0;
      oX          <= '0;
      oY          <= '0;
      oData       <= 1'b0;
      oPixelCount <= '0;
    end else begin
      oWren <= grant_valid;
      if (grant_valid) begin
        last_grant <= grant_lane;
        oX         <= iRow[32'(grant_lane) * HEIGHT_BITS +: HEIGHT_BITS];
        oY         <= iCol[32'(grant_lane) * WIDTH_BITS +: WIDTH_BITS];
        oData      <= iData[grant_lane];
        if (oPixelCount != CntMax) begin
          oPixelCount <= oPixelCount + CntW'(1);
        end
      end

      case (state)
        StIdle, StDone: begin
          if (iStart) begin
            // Lane 0 is enabled on the first RAMP cycle itself.
            state       <= StRamp;
            oLaneEnable <= NUM_LANES'(1);
            ramp_cnt    <= (LaneW+1)'(1);
            oPixelCount <= '0;
          end
        end
        StRamp: begin
          if (ramp_cnt == RampEnd) begin
            state <= StRun;
          end else begin
            oLaneEnable[ramp_cnt[LaneW-1:0]] <= 1'b1;
            ramp_cnt                         <= ramp_cnt + (LaneW+1)'(1);
          end
        end
        StRun: begin
          if ((&iLaneFinished) && !(|iValid)) begin
            state       <= StDone;
            oLaneEnable <= '0;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_result_write_arbiter.sv
// Bench for result_write_arbiter: directed literal scenarios, then random
// lane traffic compared every cycle against a frame-level behavioural model.
module tb_result_write_arbiter;

  localparam int N       = 4;
  localparam int WB      = 8;
  localparam int HB      = 8;
  localparam int CNT_CAP = 1 << (WB + HB);

  logic            clock = 1'b0;
  logic            not_reset = 1'b0;
  logic            iStart = 1'b0;
  logic [N-1:0]    iValid = '0;
  logic [N*WB-1:0] iCol = '0;
  logic [N*HB-1:0] iRow = '0;
  logic [N-1:0]    iData = '0;
  logic [N-1:0]    iLaneFinished = '0;
  logic [N-1:0]    oReady, oLaneEnable;
  logic [HB-1:0]   oX;
  logic [WB-1:0]   oY;
  logic            oData, oWren, oBusy, oDone;
  logic [WB+HB:0]  oPixelCount;

  // Small instance used only to reach pixel-count saturation quickly.
  logic       s_start = 1'b0;
  logic [1:0] s_valid = '0;
  logic [3:0] s_col = '0;
  logic [1:0] s_row = '0;
  logic [1:0] s_data = '0;
  logic [1:0] s_fin = '0;
  logic [1:0] s_ready, s_en;
  logic       s_x;
  logic [1:0] s_y;
  logic       s_odata, s_wren, s_busy, s_done;
  logic [3:0] s_cnt;

  result_write_arbiter #(
    .NUM_LANES_BITS(2), .NUM_LANES(N), .WIDTH_BITS(WB), .HEIGHT_BITS(HB)
  ) dut (
    .clock(clock), .not_reset(not_reset), .iStart(iStart), .iValid(iValid),
    .iCol(iCol), .iRow(iRow), .iData(iData), .iLaneFinished(iLaneFinished),
    .oReady(oReady), .oLaneEnable(oLaneEnable), .oX(oX), .oY(oY), .oData(oData),
    .oWren(oWren), .oBusy(oBusy), .oDone(oDone), .oPixelCount(oPixelCount)
  );

  result_write_arbiter #(
    .NUM_LANES_BITS(1), .NUM_LANES(2), .WIDTH_BITS(2), .HEIGHT_BITS(1)
  ) dut_small (
    .clock(clock), .not_reset(not_reset), .iStart(s_start), .iValid(s_valid),
    .iCol(s_col), .iRow(s_row), .iData(s_data), .iLaneFinished(s_fin),
    .oReady(s_ready), .oLaneEnable(s_en), .oX(s_x), .oY(s_y), .oData(s_odata),
    .oWren(s_wren), .oBusy(s_busy), .oDone(s_done), .oPixelCount(s_cnt)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;
  bit cmp_on = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Phase: 0 idle, 1 ramp, 2 run, 3 done. m_r = number of RAMP cycles entered.
  int            m_phase, m_r, m_last, m_cnt;
  logic          m_wren, m_d;
  logic [HB-1:0] m_x;
  logic [WB-1:0] m_y;
  int            exp_grant;
  logic [N-1:0]  exp_ready;

  function automatic logic [N-1:0] en_of(input int ph, input int r);
    if (ph == 1 || ph == 2) return N'((1 << r) - 1);
    return '0;
  endfunction

  function automatic int pick(input int ph, input int r, input int last, input logic [N-1:0] v);
    logic [N-1:0] en;
    en = en_of(ph, r);
    if (ph != 1 && ph != 2) return -1;
    for (int off = 1; off <= N; off++) begin
      int l;
      l = (last + off) % N;
      if (v[l] && en[l]) return l;
    end
    return -1;
  endfunction

  assign exp_grant = pick(m_phase, m_r, m_last, iValid);
  assign exp_ready = (exp_grant >= 0) ? N'(1 << exp_grant) : '0;

  always @(posedge clock or negedge not_reset) begin
    if (!not_reset) begin
      m_phase <= 0;
      m_r     <= 0;
      m_last  <= N - 1;
      m_cnt   <= 0;
      m_wren  <= 1'b0;
      m_x     <= '0;
      m_y     <= '0;
      m_d     <= 1'b0;
    end else begin
      if (exp_grant >= 0) begin
        m_wren <= 1'b1;
        m_last <= exp_grant;
        m_x    <= iRow[exp_grant*HB +: HB];
        m_y    <= iCol[exp_grant*WB +: WB];
        m_d    <= iData[exp_grant];
        m_cnt  <= (m_cnt < CNT_CAP) ? m_cnt + 1 : m_cnt;
      end else begin
        m_wren <= 1'b0;
      end
      if ((m_phase == 0 || m_phase == 3) && iStart) begin
        m_phase <= 1;
        m_r     <= 1;
        m_cnt   <= 0;
      end else if (m_phase == 1) begin
        if (m_r == N) m_phase <= 2;
        else m_r <= m_r + 1;
      end else if (m_phase == 2 && iLaneFinished == '1 && iValid == '0) begin
        m_phase <= 3;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    if (cmp_on) begin
      check("ready", 64'(oReady), 64'(exp_ready));
      check("lane_enable", 64'(oLaneEnable), 64'(en_of(m_phase, m_r)));
      check("busy", 64'(oBusy), 64'(m_phase == 1 || m_phase == 2));
      check("done", 64'(oDone), 64'(m_phase == 3));
      check("wren", 64'(oWren), 64'(m_wren));
      check("x", 64'(oX), 64'(m_x));
      check("y", 64'(oY), 64'(m_y));
      check("data", 64'(oData), 64'(m_d));
      check("pixel_count", 64'(oPixelCount), 64'(m_cnt));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_lane(input int l, input logic [HB-1:0] row, input logic [WB-1:0] col,
                          input logic d);
    iRow[l*HB +: HB] = row;
    iCol[l*WB +: WB] = col;
    iData[l]         = d;
  endtask

  initial begin
    logic [N-1:0] g;
    bit           fin_mode;

    #12 not_reset = 1'b1;
    cmp_on = 1'b1;
    tick();
    check("rst_enable", 64'(oLaneEnable), 64'h0);
    check("rst_busy", 64'(oBusy), 64'h0);
    check("rst_done", 64'(oDone), 64'h0);
    check("rst_wren", 64'(oWren), 64'h0);
    check("rst_count", 64'(oPixelCount), 64'h0);

    // Frame start and lane-enable ramp.
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
    check("ramp_en1", 64'(oLaneEnable), 64'h1);
    check("ramp_busy", 64'(oBusy), 64'h1);
    tick();
    check("ramp_en2", 64'(oLaneEnable), 64'h3);
    tick();
    check("ramp_en3", 64'(oLaneEnable), 64'h7);
    tick();
    check("ramp_en4", 64'(oLaneEnable), 64'hf);
    tick();
    check("run_busy", 64'(oBusy), 64'h1);

    // All lanes valid for 8 cycles: grants rotate 0,1,2,3,...
    for (int l = 0; l < N; l++) set_lane(l, HB'(l + 1), WB'(8'h40 + l), l[0]);
    iValid = '1;
    #1;
    for (int k = 0; k < 8; k++) begin
      check("rr_ready", 64'(oReady), 64'(1 << (k % N)));
      tick();
      check("rr_wren", 64'(oWren), 64'h1);
      check("rr_x", 64'(oX), 64'((k % N) + 1));
      check("rr_y", 64'(oY), 64'(8'h40 + (k % N)));
    end
    iValid = '0;
    #1;
    check("rr_count", 64'(oPixelCount), 64'd8);

    // Only lane 2 valid.
    set_lane(2, 8'h10, 8'h20, 1'b1);
    iValid = 4'b0100;
    #1;
    check("lone2_ready", 64'(oReady), 64'h4);
    tick();
    iValid = '0;
    check("lone2_wren", 64'(oWren), 64'h1);
    check("lone2_x", 64'(oX), 64'h10);
    check("lone2_y", 64'(oY), 64'h20);
    check("lone2_data", 64'(oData), 64'h1);

    // A lone valid lane is granted every cycle.
    iValid = 4'b0010;
    #1;
    for (int k = 0; k < 3; k++) begin
      check("lone1_ready", 64'(oReady), 64'h2);
      tick();
      check("lone1_wren", 64'(oWren), 64'h1);
    end
    iValid = '0;
    #1;
    check("lone1_count", 64'(oPixelCount), 64'd12);

    // Finish while lanes 2 and 3 still hold pixels; lane 3 is granted last.
    iLaneFinished = '1;
    iValid = 4'b1100;
    #1;
    check("fin_ready2", 64'(oReady), 64'h4);
    tick();
    iValid = 4'b1000;
    #1;
    check("fin_ready3", 64'(oReady), 64'h8);
    check("fin_not_done_a", 64'(oDone), 64'h0);
    tick();
    iValid = '0;
    #1;
    check("fin_not_done_b", 64'(oDone), 64'h0);
    check("fin_still_busy", 64'(oBusy), 64'h1);
    tick();
    check("fin_done", 64'(oDone), 64'h1);
    check("fin_enable", 64'(oLaneEnable), 64'h0);
    check("fin_busy", 64'(oBusy), 64'h0);
    iValid = '1;
    #1;
    check("fin_ready_zero", 64'(oReady), 64'h0);
    iValid = '0;

    // Restart from DONE, then reset mid-run with every lane valid.
    iLaneFinished = '0;
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
    check("restart_count", 64'(oPixelCount), 64'h0);
    repeat (4) tick();
    iValid = '1;
    tick();
    tick();
    not_reset = 1'b0;
    #1;
    check("mid_rst_enable", 64'(oLaneEnable), 64'h0);
    check("mid_rst_ready", 64'(oReady), 64'h0);
    check("mid_rst_wren", 64'(oWren), 64'h0);
    check("mid_rst_xy", 64'({oX, oY, oData}), 64'h0);
    check("mid_rst_count", 64'(oPixelCount), 64'h0);
    check("mid_rst_busy", 64'({oBusy, oDone}), 64'h0);
    #2 not_reset = 1'b1;
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
    check("after_rst_ready", 64'(oReady), 64'h1);

    // Random traffic: lanes hold pixels until granted, frames start and finish.
    for (int c = 0; c < 1500; c++) begin
      @(negedge clock);
      g = oReady & iValid;
      tick();
      fin_mode = (c % 100) >= 70;
      iStart = ($urandom_range(0, 19) == 0);
      iLaneFinished = fin_mode ? '1 : (N'($urandom) & N'($urandom));
      for (int l = 0; l < N; l++) begin
        if (g[l] || !iValid[l]) begin
          if (!fin_mode && $urandom_range(0, 9) < 6) begin
            iValid[l] = 1'b1;
            set_lane(l, HB'($urandom), WB'($urandom), 1'($urandom));
          end else begin
            iValid[l] = 1'b0;
          end
        end
      end
    end
    iStart = 1'b0;
    iValid = '0;
    tick();

    // Pixel-count saturation on the small instance (cap = 8).
    s_valid = 2'b01;
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    repeat (5) tick();
    check("small_count5", 64'(s_cnt), 64'd5);
    check("small_busy", 64'({s_busy, s_done}), 64'h2);
    repeat (7) tick();
    check("small_count_sat", 64'(s_cnt), 64'd8);
    check("small_wren", 64'(s_wren), 64'h1);
    s_valid = '0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
